// File: rtl/fifo_ram_ctrl_if.sv
// fifo_ram_ctrl_if
//   Bundles the request side (push/pop) and the RAM/status side of the
//   FIFO controller into one interface.
//   master : producer/consumer plus RAM model (drives push, push_data, pop)
//   slave  : fifo_ram_ctrl (drives RAM controls, status and error flags)
interface fifo_ram_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;

  logic                  ram_en_w;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic                  ram_en_r;
  logic [ADDR_WIDTH-1:0] ram_read_addr;

  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output push, push_data, pop,
    input  ram_en_w, ram_data, ram_write_addr, ram_en_r, ram_read_addr,
    input  rd_valid, count, full, empty, almost_full, err_ovf, err_udf
  );

  modport slave (
    input  push, push_data, pop,
    output ram_en_w, ram_data, ram_write_addr, ram_en_r, ram_read_addr,
    output rd_valid, count, full, empty, almost_full, err_ovf, err_udf
  );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl
//   Single-clock FIFO control stage in front of a simple dual-port RAM with
//   a registered read port. Converts push/pop requests into RAM write/read
//   enables and addresses, tracks occupancy and status, and raises rd_valid
//   in the cycle the RAM output holds the popped word.
// Ports
//   clk  : clock for all state
//   rst  : asynchronous reset, active low
//   bus  : fifo_ram_ctrl_if.slave (requests in; RAM controls, status out)
module fifo_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic            clk,
  input  logic            rst,
  fifo_ram_ctrl_if.slave  bus
);

  localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  err_ovf_q,  err_ovf_d;
  logic                  err_udf_q,  err_udf_d;

  logic full_s, empty_s, af_s;
  logic pop_ok, push_ok;

  always_comb begin
    empty_s = (count_q == '0);
    full_s  = (count_q == DEPTH_C);
    af_s    = (count_q >= AF_C);
  end

  // A push while full is only taken when a pop frees the slot in the same
  // cycle; the RAM reads before it writes, so the pop still sees the old word.
  always_comb begin
    pop_ok  = bus.pop & ~empty_s;
    push_ok = bus.push & (~full_s | pop_ok);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = pop_ok;
    err_ovf_d  = err_ovf_q | (bus.push & ~push_ok);
    err_udf_d  = err_udf_q | (bus.pop & ~pop_ok);

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      err_ovf_q  <= err_ovf_d;
      err_udf_q  <= err_udf_d;
    end
  end

  // Enables are gated by rst so a request held during reset cannot reach the RAM.
  assign bus.ram_en_w       = push_ok & rst;
  assign bus.ram_data       = bus.push_data;
  assign bus.ram_write_addr = wr_ptr_q;
  assign bus.ram_en_r       = pop_ok & rst;
  assign bus.ram_read_addr  = rd_ptr_q;

  assign bus.rd_valid    = rd_valid_q;
  assign bus.count       = count_q;
  assign bus.full        = full_s;
  assign bus.empty       = empty_s;
  assign bus.almost_full = af_s;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_udf     = err_udf_q;

endmodule
